// File: rtl/clock_panel.sv
// Front-panel button conditioner: each raw button is synchronised, debounced and
// turned into a fixed-width, gap-enforced pulse for the clock module, plus LED mirrors.

module clock_panel_lane #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PULSE_CYCLES    = 12500
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic btn_i,
    input  logic accept_i,
    output logic press_o,
    output logic idle_o,
    output logic pulse_o
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    logic [1:0]    sync;
    logic          db, db_d;
    logic [DW-1:0] db_cnt;
    state_t        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            db     <= 1'b0;
            db_d   <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync <= {sync[0], btn_i};
            db_d <= db;
            // any agreeing cycle restarts the window, so one glitch costs a full window
            if (sync[1] == db) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                db     <= ~db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    // only the debounced rising edge is a press; release is ignored
    assign press_o = db & ~db_d;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_i) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end
            end
            HIGH, GAP: begin
                if (cnt_q == PW'(PULSE_CYCLES - 1)) begin
                    state_d = (state_q == HIGH) ? GAP : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign idle_o  = (state_q == IDLE);
    assign pulse_o = (state_q == HIGH);
endmodule

module clock_panel #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PULSE_CYCLES    = 12500
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       btn_start_stop_i,
    input  logic       btn_step_i,
    input  logic       btn_speed_i,
    output logic       clk_start_stop_o,
    output logic       clk_step_o,
    output logic       clk_speed_o,
    output logic       running_o,
    output logic [1:0] speed_idx_o
);
    localparam int NUM_BTN = 3;

    logic [NUM_BTN-1:0] btn, press, idle, pulse, accept;
    logic               acc_ss, acc_step, acc_speed;
    logic               running_q;
    logic [1:0]         speed_q;

    assign btn = {btn_speed_i, btn_step_i, btn_start_stop_i};

    clock_panel_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .PULSE_CYCLES   (PULSE_CYCLES)
    ) u_lane [NUM_BTN-1:0] (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .btn_i   (btn),
        .accept_i(accept),
        .press_o (press),
        .idle_o  (idle),
        .pulse_o (pulse)
    );

    // start/stop beats step in the same cycle; step qualifies on pre-toggle run state
    assign acc_ss    = press[0] & idle[0];
    assign acc_step  = press[1] & idle[1] & ~running_q & ~acc_ss;
    assign acc_speed = press[2] & idle[2];
    assign accept    = {acc_speed, acc_step, acc_ss};

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b1;
            speed_q   <= 2'd0;
        end else begin
            if (acc_ss)    running_q <= ~running_q;
            if (acc_speed) speed_q   <= speed_q + 2'd1;
        end
    end

    assign clk_start_stop_o = pulse[0];
    assign clk_step_o       = pulse[1];
    assign clk_speed_o      = pulse[2];
    assign running_o        = running_q;
    assign speed_idx_o      = speed_q;
endmodule

// File: doc/clock_panel.md
# clock_panel

Front-panel input conditioner that drives the clock module's control inputs (`clk_start_stop_i`, `clk_step_i`, `clk_speed_i`). It takes three raw, bouncy push-button inputs and passes each through a synchroniser and a debouncer. It emits clean, fixed-width pulses, so the downstream edge-triggered logic sees exactly one rising edge per physical press. It also keeps mirrors of the run state and the speed index for display LEDs, and lets a step request through only while the clock is halted.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive `clk_i` cycles a synchronised input must differ from its debounced state before the state flips. Must be ≥ 2.
- `PULSE_CYCLES`, default 12500: high time of each output pulse, and also the mandatory low gap after it. Must be ≥ 1.
- `clk_i`, input, 1: system clock. Single clock domain.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `btn_start_stop_i`, input, 1: raw start/stop button, active-high, asynchronous.
- `btn_step_i`, input, 1: raw single-step button, active-high, asynchronous.
- `btn_speed_i`, input, 1: raw speed-cycle button, active-high, asynchronous.
- `clk_start_stop_o`, output, 1: start/stop pulse to the clock module.
- `clk_step_o`, output, 1: step pulse to the clock module.
- `clk_speed_o`, output, 1: speed-advance pulse to the clock module.
- `running_o`, output, 1: mirror of the run state. 1 = free-running, 0 = halted.
- `speed_idx_o`, output, 2: mirror of the speed index, range 0..3.

## Operation
- **Synchroniser.** Each button passes through a 2-flop synchroniser. The debouncer only ever sees the synchronised value.
- **Debouncer.** There is one counter per button, with width `$clog2(DEBOUNCE_CYCLES+1)`.
  - While the synchronised value differs from the debounced state, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the values still differ, the debounced state flips on the next edge and the counter clears.
  - Any cycle where the values are equal clears the counter. A single glitch therefore restarts the debounce window.
- **Press event.** A press event is a 0→1 transition of a debounced state. A 1→0 transition (release) generates nothing.
- **Pulse FSM.** There is one FSM per output, with states IDLE, HIGH and GAP.
  - IDLE → HIGH on an accepted press. The output goes high on that edge.
  - HIGH → GAP after `PULSE_CYCLES` cycles. The output goes low.
  - GAP → IDLE after `PULSE_CYCLES` cycles.
  - Press events arriving while the FSM is in HIGH or GAP are dropped, not queued.
- **Acceptance rules.**
  - Start/stop: accepted in IDLE. On acceptance, `running_o` toggles on the same edge that raises `clk_start_stop_o`.
  - Step: accepted only in IDLE with `running_o`=0. A step press while running is dropped.
  - Speed: accepted in IDLE. On acceptance, `speed_idx_o` increments modulo 4 (3→0) on the same edge that raises `clk_speed_o`.
- **Simultaneous events.**
  - If a start/stop press and a step press are accepted in the same cycle, start/stop wins and the step press is dropped. The step qualification uses the pre-toggle `running_o`, and the step is suppressed either way.
  - Speed is independent of the other two buttons and may fire in the same cycle as either.
- **Reset values.**
  - All pulse outputs 0.
  - `running_o` = 1, matching the clock module's power-up run state.
  - `speed_idx_o` = 0.
  - Synchronisers, debounced states and counters all 0.
  - Pulse FSMs in IDLE.
- **Reset mid-operation.** Asserting `rst_n` low forces all of the above asynchronously, including in the middle of a pulse. A button held through reset release produces exactly one press after the normal debounce latency.

## Timing
- **Press latency.** Raw input rises and stays stable; the corresponding output rises 3 + `DEBOUNCE_CYCLES` edges after the first edge that samples the raw input high. This is made up of:
  - 2 edges for the synchroniser;
  - `DEBOUNCE_CYCLES` edges for the debounce window;
  - 1 edge for the registered output.
- **Pulse shape.** Exactly `PULSE_CYCLES` cycles high, followed by at least `PULSE_CYCLES` cycles low. The minimum period between two accepted pulses on the same output is therefore 2×`PULSE_CYCLES`.
- **Mirror timing.** `running_o` and `speed_idx_o` update on the same edge as the rising edge of their output pulse.
- **Registered outputs.** All outputs are registered; none has a combinational path from any input.

## Test plan
Directed tests use `DEBOUNCE_CYCLES`=4 and `PULSE_CYCLES`=3.

1. **Clean start/stop press.** Drive `btn_start_stop_i` high and hold it for 20 cycles. Required: `clk_start_stop_o` high for cycles 7–9 and low from cycle 10; `running_o` goes 1→0 at cycle 7; no other output moves.
2. **Bounce rejection.** Toggle `btn_speed_i` every 2 cycles for 30 cycles, then hold it low for 20 cycles. Required: `clk_speed_o` never rises and `speed_idx_o` stays 0.
3. **Step gating.**
   - Press step while `running_o`=1. Required: no `clk_step_o` pulse.
   - Then press start/stop, which sets `running_o`=0, and press step again. Required: exactly one 3-cycle `clk_step_o` pulse.
4. **Speed wrap.** Make 5 clean speed presses spaced 20 cycles apart. Required: five 3-cycle pulses; `speed_idx_o` sequence 1, 2, 3, 0, 1.
5. **Drop during pulse or gap.** Time a second clean speed press so that its debounced press event lands 2 cycles after the first pulse falls, i.e. in GAP. Required: only one pulse, and `speed_idx_o` advances by exactly 1.
6. **Reset mid-pulse.** Pull `rst_n` low while `clk_start_stop_o` is high, then release it with all buttons released. Required: all pulse outputs 0 immediately (asynchronously); `running_o`=1; `speed_idx_o`=0; no pulse follows the release.
